// File: rtl/bp_fe_bp_update_queue.sv
// In-order queue of in-flight branch predictions feeding registered predictor updates.
// Optional BP_UPDQ_STATS_EN adds saturating resolved/mispredict counters.
module bp_fe_bp_update_queue #(
  parameter int unsigned bht_idx_width_p = 9,
  parameter int unsigned queue_els_p     = 8,
  localparam int unsigned ptr_width_lp   = $clog2(queue_els_p),
  localparam int unsigned cnt_width_lp   = $clog2(queue_els_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       pred_v_i,
  input  logic [bht_idx_width_p-1:0] pred_idx_i,
  input  logic                       pred_taken_i,
  output logic                       pred_ready_o,
  input  logic                       res_v_i,
  input  logic                       res_taken_i,
  output logic                       res_ready_o,
  input  logic                       flush_i,
  output logic                       w_v_o,
  output logic [bht_idx_width_p-1:0] idx_w_o,
  output logic                       correct_o,
  output logic [cnt_width_lp-1:0]    count_o,
`ifdef BP_UPDQ_STATS_EN
  output logic [31:0]                stat_resolved_o,
  output logic [31:0]                stat_mispred_o,
`endif
  output logic                       underflow_o
);

  logic [bht_idx_width_p-1:0] idx_mem [queue_els_p];
  logic                       taken_mem [queue_els_p];

  logic [ptr_width_lp-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ptr_width_lp-1:0]    rd_ptr_q, rd_ptr_d;
  logic [cnt_width_lp-1:0]    count_q, count_d;
  logic                       w_v_q, w_v_d;
  logic [bht_idx_width_p-1:0] idx_w_q, idx_w_d;
  logic                       correct_q, correct_d;
  logic                       underflow_q, underflow_d;

  logic push, pop, pop_correct;

  // Ready flags depend on registered occupancy only, never on same-cycle inputs.
  assign pred_ready_o = (count_q != cnt_width_lp'(queue_els_p));
  assign res_ready_o  = (count_q != '0);

  assign push        = pred_v_i & pred_ready_o & ~flush_i;
  assign pop         = res_v_i & res_ready_o;
  assign pop_correct = (taken_mem[rd_ptr_q] == res_taken_i);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    w_v_d       = pop;
    idx_w_d     = idx_w_q;
    correct_d   = correct_q;
    underflow_d = underflow_q | (res_v_i & ~res_ready_o);

    if (push) wr_ptr_d = wr_ptr_q + ptr_width_lp'(1);
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + ptr_width_lp'(1);
      idx_w_d   = idx_mem[rd_ptr_q];
      correct_d = pop_correct;
    end

    // A pop in the flush cycle still reports; the queue then empties at the write pointer.
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + cnt_width_lp'(1);
        2'b01:   count_d = count_q - cnt_width_lp'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      w_v_q       <= 1'b0;
      idx_w_q     <= '0;
      correct_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      w_v_q       <= w_v_d;
      idx_w_q     <= idx_w_d;
      correct_q   <= correct_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      idx_mem[wr_ptr_q]   <= pred_idx_i;
      taken_mem[wr_ptr_q] <= pred_taken_i;
    end
  end

  assign w_v_o       = w_v_q;
  assign idx_w_o     = idx_w_q;
  assign correct_o   = correct_q;
  assign count_o     = count_q;
  assign underflow_o = underflow_q;

`ifdef BP_UPDQ_STATS_EN
  logic [31:0] resolved_q, mispred_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      resolved_q <= '0;
      mispred_q  <= '0;
    end else begin
      if (pop && resolved_q != '1) resolved_q <= resolved_q + 32'd1;
      if (pop && !pop_correct && mispred_q != '1) mispred_q <= mispred_q + 32'd1;
    end
  end

  assign stat_resolved_o = resolved_q;
  assign stat_mispred_o  = mispred_q;
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_bp_fe_bp_update_queue.sv
// Self-checking bench: table vectors, directed corner sequences and a random run
// against a queue-based reference model.
module tb_bp_fe_bp_update_queue;
  localparam int unsigned Depth = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pred_v = 1'b0, pred_taken = 1'b0, res_v = 1'b0, res_taken = 1'b0, flush = 1'b0;
  logic [8:0] pred_idx = '0;
  logic       pred_ready, res_ready, w_v, correct, underflow;
  logic [8:0] idx_w;
  logic [3:0] count;

  bp_fe_bp_update_queue dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .pred_v_i    (pred_v),
    .pred_idx_i  (pred_idx),
    .pred_taken_i(pred_taken),
    .pred_ready_o(pred_ready),
    .res_v_i     (res_v),
    .res_taken_i (res_taken),
    .res_ready_o (res_ready),
    .flush_i     (flush),
    .w_v_o       (w_v),
    .idx_w_o     (idx_w),
    .correct_o   (correct),
    .count_o     (count),
    .underflow_o (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] idx;
    bit         taken;
  } entry_t;

  entry_t     q[$];
  bit         m_wv, m_cor, m_uf;
  logic [8:0] m_idx;

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_wv = 0; m_cor = 0; m_uf = 0; m_idx = '0;
  endtask

  // Reference: pop happens against the pre-edge contents; flush empties after the pop.
  task automatic model_step(input bit pv, input logic [8:0] pidx, input bit pt,
                            input bit rv, input bit rt, input bit fl);
    int sz = q.size();
    entry_t e;
    if (rv && sz != 0) begin
      e = q.pop_front();
      m_wv = 1; m_idx = e.idx; m_cor = (e.taken == rt);
    end else begin
      m_wv = 0;
    end
    if (rv && sz == 0) m_uf = 1;
    if (fl) q.delete();
    else if (pv && sz != Depth) begin
      e.idx = pidx; e.taken = pt;
      q.push_back(e);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".w_v"}, w_v, m_wv);
    chk({tag, ".idx_w"}, idx_w, m_idx);
    chk({tag, ".correct"}, correct, m_cor);
    chk({tag, ".count"}, count, q.size());
    chk({tag, ".pred_ready"}, pred_ready, q.size() != Depth);
    chk({tag, ".res_ready"}, res_ready, q.size() != 0);
    chk({tag, ".underflow"}, underflow, m_uf);
  endtask

  task automatic step(input string tag, input bit pv, input logic [8:0] pidx, input bit pt,
                      input bit rv, input bit rt, input bit fl);
    pred_v = pv; pred_idx = pidx; pred_taken = pt;
    res_v = rv; res_taken = rt; flush = fl;
    model_step(pv, pidx, pt, rv, rt, fl);
    @(posedge clk);
    #1;
    pred_v = 0; res_v = 0; flush = 0; pred_idx = '0; pred_taken = 0; res_taken = 0;
    check_all(tag);
  endtask

  typedef struct {
    bit         pv;
    logic [8:0] idx;
    bit         pt;
    bit         rv;
    bit         rt;
    bit         e_wv;
    logic [8:0] e_idx;
    bit         e_cor;
    int         e_cnt;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1, 9'd5,  1, 0, 0, 0, 9'd0,  0, 1};
    tbl[1] = '{1, 9'd9,  0, 0, 0, 0, 9'd0,  0, 2};
    tbl[2] = '{1, 9'd17, 1, 0, 0, 0, 9'd0,  0, 3};
    tbl[3] = '{0, 9'd0,  0, 1, 1, 1, 9'd5,  1, 2};
    tbl[4] = '{0, 9'd0,  0, 1, 1, 1, 9'd9,  0, 1};
    tbl[5] = '{0, 9'd0,  0, 1, 0, 1, 9'd17, 0, 0};
    tbl[6] = '{0, 9'd0,  0, 0, 0, 0, 9'd17, 0, 0};

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_all("reset");

    // Basic prediction/resolve sequence with fixed expected updates
    foreach (tbl[i]) begin
      step("tbl", tbl[i].pv, tbl[i].idx, tbl[i].pt, tbl[i].rv, tbl[i].rt, 0);
      chk("tbl.w_v", w_v, tbl[i].e_wv);
      chk("tbl.idx_w", idx_w, tbl[i].e_idx);
      chk("tbl.correct", correct, tbl[i].e_cor);
      chk("tbl.count", count, tbl[i].e_cnt);
    end

    // Fill to capacity; extra push is dropped; push+pop while full refuses the push
    for (int i = 0; i < 8; i++) step("fill", 1, 9'(i * 7 + 3), i[0], 0, 0, 0);
    chk("full.pred_ready", pred_ready, 0);
    step("over", 1, 9'd400, 1, 0, 0, 0);
    chk("over.count", count, 8);
    step("fullpop", 1, 9'd401, 1, 1, 1, 0);
    chk("fullpop.idx", idx_w, 9'd3);
    chk("fullpop.count", count, 7);
    for (int i = 0; i < 7; i++) step("drain", 0, 0, 0, 1, $urandom_range(0, 1), 0);
    chk("drain.idx", idx_w, 9'd52);
    for (int i = 0; i < 3; i++) step("wrap_push", 1, 9'(100 + i), 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step("wrap_pop", 0, 0, 0, 1, 1, 0);
      chk("wrap.idx", idx_w, 9'(100 + i));
    end

    // Occupancy 4 held by simultaneous push and pop
    for (int i = 0; i < 4; i++) step("occ_fill", 1, 9'(200 + i), 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step("occ", 1, 9'(204 + i), 1, 1, 0, 0);
      chk("occ.count", count, 4);
      chk("occ.idx", idx_w, 9'(200 + i));
    end
    for (int i = 0; i < 4; i++) step("occ_drain", 0, 0, 0, 1, 0, 0);

    // Flush with a resolve: only the oldest entry reports
    for (int i = 0; i < 3; i++) step("fl_fill", 1, 9'(300 + i), 1, 0, 0, 0);
    step("flush", 1, 9'd310, 1, 1, 1, 1);
    chk("flush.w_v", w_v, 1);
    chk("flush.idx", idx_w, 9'd300);
    chk("flush.count", count, 0);
    chk("flush.res_ready", res_ready, 0);
    step("flush_after", 0, 0, 0, 0, 0, 0);
    chk("flush_after.w_v", w_v, 0);

    // No bypass: push+resolve on empty is an underflow, entry stays
    step("nobypass", 1, 9'd77, 0, 1, 0, 0);
    chk("nobypass.w_v", w_v, 0);
    chk("nobypass.uf", underflow, 1);
    chk("nobypass.count", count, 1);
    step("nb_pop", 0, 0, 0, 1, 0, 0);
    chk("nb_pop.idx", idx_w, 9'd77);
    step("empty_res", 0, 0, 0, 1, 1, 0);
    chk("empty_res.w_v", w_v, 0);
    chk("empty_res.uf", underflow, 1);

    // Asynchronous reset mid-cycle clears the sticky flag before the next edge
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("areset.uf", underflow, 0);
    chk("areset.count", count, 0);
    chk("areset.pred_ready", pred_ready, 1);
    #2 reset_n = 1'b1;

    // Random run against the reference model
    for (int i = 0; i < 600; i++) begin
      step("rand", $urandom_range(0, 99) < 60, 9'($urandom_range(0, 511)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 50,
           $urandom_range(0, 1) == 1, $urandom_range(0, 99) < 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
